// File: rtl/alu_rr_arbiter.sv
// ============================================================================
//  Module      : alu_rr_arbiter
//  Description : Round-robin sharing of one combinational ALU between two
//                valid/ready requesters, with a registered response path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rr_arbiter #(
    parameter int DATA_W       = 8,
    parameter int SEL_W        = 3,
    parameter int ISSUE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic [SEL_W-1:0]  r0_s,
    output logic              r0_rvalid,
    input  logic              r0_rready,
    output logic [DATA_W-1:0] r0_result,
    output logic [3:0]        r0_flags,

    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic [SEL_W-1:0]  r1_s,
    output logic              r1_rvalid,
    input  logic              r1_rready,
    output logic [DATA_W-1:0] r1_result,
    output logic [3:0]        r1_flags,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_s,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_cout,
    input  logic              alu_ovf,
    input  logic              alu_neg,

    output logic              busy,
    output logic              grant_id
);

    localparam int         C_CNT_W    = 4;
    localparam logic [3:0] C_CNT_LOAD = C_CNT_W'(ISSUE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [SEL_W-1:0]    s_q;
    logic [DATA_W-1:0]   result_q;
    logic [3:0]          flags_q;
    logic                rvalid0_q;
    logic                rvalid1_q;
    logic                busy_q;
    logic                grant_q;
    logic                last_q;
    logic [C_CNT_W-1:0]  cnt_q;

    logic w_idle;
    logic w_pick0;
    logic w_pick1;
    logic w_take;

    // On contention the requester that was not served last wins.
    assign w_idle  = (state_q == IDLE);
    assign w_pick0 = r0_valid && (!r1_valid || last_q);
    assign w_pick1 = r1_valid && (!r0_valid || !last_q);
    assign w_take  = grant_q ? r1_rready : r0_rready;

    assign r0_ready  = w_idle && w_pick0;
    assign r1_ready  = w_idle && w_pick1;

    assign r0_rvalid = rvalid0_q;
    assign r1_rvalid = rvalid1_q;
    assign r0_result = result_q;
    assign r1_result = result_q;
    assign r0_flags  = flags_q;
    assign r1_flags  = flags_q;

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_s     = s_q;
    assign busy      = busy_q;
    assign grant_id  = grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            busy_q    <= 1'b0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_pick0) begin
                        a_q     <= r0_a;
                        b_q     <= r0_b;
                        s_q     <= r0_s;
                        grant_q <= 1'b0;
                        last_q  <= 1'b0;
                        cnt_q   <= C_CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end else if (w_pick1) begin
                        a_q     <= r1_a;
                        b_q     <= r1_b;
                        s_q     <= r1_s;
                        grant_q <= 1'b1;
                        last_q  <= 1'b1;
                        cnt_q   <= C_CNT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        result_q  <= alu_out;
                        flags_q   <= {alu_zero, alu_cout, alu_ovf, alu_neg};
                        rvalid0_q <= !grant_q;
                        rvalid1_q <= grant_q;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (w_take) begin
                        rvalid0_q <= 1'b0;
                        rvalid1_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
// ============================================================================
//  Module      : tb_alu_rr_arbiter
//  Description : Scoreboard bench for alu_rr_arbiter with an XOR ALU stub.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rr_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // DUT with ISSUE_CYCLES=1
    logic       r0_valid = 0, r0_ready, r0_rvalid, r0_rready = 1;
    logic [7:0] r0_a = 0, r0_b = 0, r0_result;
    logic [2:0] r0_s = 0;
    logic [3:0] r0_flags;
    logic       r1_valid = 0, r1_ready, r1_rvalid, r1_rready = 1;
    logic [7:0] r1_a = 0, r1_b = 0, r1_result;
    logic [2:0] r1_s = 0;
    logic [3:0] r1_flags;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [2:0] alu_s;
    logic       busy, grant_id;

    assign alu_out = alu_a ^ alu_b;

    alu_rr_arbiter #(.DATA_W(8), .SEL_W(3), .ISSUE_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_s(r0_s),
        .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_result(r0_result), .r0_flags(r0_flags),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_s(r1_s),
        .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_result(r1_result), .r1_flags(r1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
        .alu_zero(alu_out == 8'h00), .alu_cout(alu_s[0]), .alu_ovf(alu_s[1]), .alu_neg(alu_out[7]),
        .busy(busy), .grant_id(grant_id)
    );

    // DUT with ISSUE_CYCLES=4, only requester 0 is exercised
    logic       d4_r0_valid = 0, d4_r0_ready, d4_r0_rvalid;
    logic [7:0] d4_r0_a = 0, d4_r0_b = 0, d4_r0_result;
    logic [2:0] d4_r0_s = 0;
    logic [3:0] d4_r0_flags;
    logic       d4_r1_ready, d4_r1_rvalid;
    logic [7:0] d4_r1_result;
    logic [3:0] d4_r1_flags;
    logic [7:0] d4_alu_a, d4_alu_b, d4_alu_out;
    logic [2:0] d4_alu_s;
    logic       d4_busy, d4_grant_id;

    assign d4_alu_out = d4_alu_a ^ d4_alu_b;

    alu_rr_arbiter #(.DATA_W(8), .SEL_W(3), .ISSUE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .r0_valid(d4_r0_valid), .r0_ready(d4_r0_ready), .r0_a(d4_r0_a), .r0_b(d4_r0_b), .r0_s(d4_r0_s),
        .r0_rvalid(d4_r0_rvalid), .r0_rready(1'b1), .r0_result(d4_r0_result), .r0_flags(d4_r0_flags),
        .r1_valid(1'b0), .r1_ready(d4_r1_ready), .r1_a(8'h00), .r1_b(8'h00), .r1_s(3'b000),
        .r1_rvalid(d4_r1_rvalid), .r1_rready(1'b1), .r1_result(d4_r1_result), .r1_flags(d4_r1_flags),
        .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_s(d4_alu_s), .alu_out(d4_alu_out),
        .alu_zero(d4_alu_out == 8'h00), .alu_cout(d4_alu_s[0]), .alu_ovf(d4_alu_s[1]),
        .alu_neg(d4_alu_out[7]),
        .busy(d4_busy), .grant_id(d4_grant_id)
    );

    typedef struct packed {
        logic       id;
        logic [7:0] res;
        logic [3:0] flg;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic id, input logic [7:0] res, input logic [3:0] flg);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.flg = flg;
        sb.push_back(e);
    endtask

    // Call right after posedge+#1; returns at the negedge where a ready is seen.
    task automatic wait_ready(output int got, output int at_cyc);
        int n;
        n = 0;
        got = -1;
        @(negedge clk);
        while (!(r0_ready || r1_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        at_cyc = cyc;
        if (r0_ready) got = 0;
        else if (r1_ready) got = 1;
        else begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got=none expected=a ready within 50 cycles");
        end
    endtask

    // Response monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (r0_rvalid || r1_rvalid)) begin
            chk("rvalid_exclusive", {31'd0, r0_rvalid && r1_rvalid}, 32'd0);
            if ((r0_rvalid && r0_rready) || (r1_rvalid && r1_rready)) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got=response on port %0d expected=none", r1_rvalid);
                end else begin
                    e = sb.pop_front();
                    chk("resp_port", {31'd0, r1_rvalid}, {31'd0, e.id});
                    chk("resp_result", {24'd0, r1_rvalid ? r1_result : r0_result}, {24'd0, e.res});
                    chk("resp_flags", {28'd0, r1_rvalid ? r1_flags : r0_flags}, {28'd0, e.flg});
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got=no finish expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int got, at, prev, n;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant", {31'd0, grant_id}, 32'd0);
        chk("rst_alu", {13'd0, alu_a, alu_b, alu_s}, 32'd0);
        chk("rst_rvalid", {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
        chk("rst_resflags", {20'd0, r0_result, r0_flags}, 32'd0);

        // 1: single r0 request
        @(posedge clk); #1;
        push(1'b0, 8'hFF, 4'b0111);
        r0_a = 8'h0F; r0_b = 8'hF0; r0_s = 3'b011; r0_valid = 1;
        wait_ready(got, at);
        chk("t1_ready", got, 0);
        @(posedge clk); #1;
        r0_valid = 0;
        n = 1;
        while (!r0_rvalid && n < 20) begin
            chk("t1_r1_rvalid_low", {31'd0, r1_rvalid}, 32'd0);
            @(posedge clk); #1;
            n++;
        end
        chk("t1_latency", n, 2);
        chk("t1_r1_rvalid_low", {31'd0, r1_rvalid}, 32'd0);
        repeat (2) @(posedge clk);

        // 2: both valid from reset, r0 first
        #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        push(1'b0, 8'h00, 4'b1000);
        push(1'b1, 8'h80, 4'b0011);
        r0_a = 8'h12; r0_b = 8'h12; r0_s = 3'd0; r0_valid = 1;
        r1_a = 8'h80; r1_b = 8'h00; r1_s = 3'd2; r1_valid = 1;
        wait_ready(got, at);
        chk("t2_first", got, 0);
        @(posedge clk); #1;
        r0_valid = 0;
        chk("t2_grant0", {31'd0, grant_id}, 32'd0);
        wait_ready(got, at);
        chk("t2_second", got, 1);
        @(posedge clk); #1;
        r1_valid = 0;
        chk("t2_grant1", {31'd0, grant_id}, 32'd1);
        repeat (4) @(posedge clk);
        #1;

        // 3: continuous contention alternates grants, 3 cycles apart
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push(1'b0, 8'h3C, 4'b0100);
            else            push(1'b1, 8'h00, 4'b1110);
        end
        r0_a = 8'h33; r0_b = 8'h0F; r0_s = 3'd1; r0_valid = 1;
        r1_a = 8'hAA; r1_b = 8'hAA; r1_s = 3'd7; r1_valid = 1;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            wait_ready(got, at);
            chk("t3_grant_seq", got, i % 2);
            if (i > 0) chk("t3_spacing", at - prev, 3);
            prev = at;
            @(posedge clk); #1;
        end
        r0_valid = 0;
        r1_valid = 0;
        repeat (4) @(posedge clk);
        #1;

        // 4: backpressure on r1
        push(1'b1, 8'h55, 4'b0100);
        push(1'b0, 8'h80, 4'b0001);
        r1_rready = 0;
        r1_a = 8'h5A; r1_b = 8'h0F; r1_s = 3'd5; r1_valid = 1;
        wait_ready(got, at);
        chk("t4_first", got, 1);
        @(posedge clk); #1;
        r1_valid = 0;
        r0_a = 8'h01; r0_b = 8'h81; r0_s = 3'd0; r0_valid = 1;
        n = 0;
        @(negedge clk);
        while (!r1_rvalid && n < 20) begin
            chk("t4_r0_ready_issue", {31'd0, r0_ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_rvalid", {31'd0, r1_rvalid}, 32'd1);
            chk("t4_hold_result", {24'd0, r1_result}, 32'h55);
            chk("t4_hold_flags", {28'd0, r1_flags}, 32'h4);
            chk("t4_r0_ready_low", {31'd0, r0_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        r1_rready = 1;
        @(posedge clk); #1;
        wait_ready(got, at);
        chk("t4_after_release", got, 0);
        @(posedge clk); #1;
        r0_valid = 0;
        repeat (4) @(posedge clk);
        #1;

        // 5: ISSUE_CYCLES=4 latency and operand stability
        d4_r0_a = 8'hC3; d4_r0_b = 8'h3C; d4_r0_s = 3'd3; d4_r0_valid = 1;
        n = 0;
        @(negedge clk);
        while (!d4_r0_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_ready", {31'd0, d4_r0_ready}, 32'd1);
        @(posedge clk); #1;
        d4_r0_valid = 0;
        d4_r0_a = 8'h00; d4_r0_b = 8'h00; d4_r0_s = 3'd0;
        n = 1;
        while (!d4_r0_rvalid && n < 20) begin
            chk("t5_alu_stable", {13'd0, d4_alu_a, d4_alu_b, d4_alu_s}, {13'd0, 8'hC3, 8'h3C, 3'd3});
            @(posedge clk); #1;
            n++;
        end
        chk("t5_latency", n, 5);
        chk("t5_result", {20'd0, d4_r0_result, d4_r0_flags}, {20'd0, 8'hFF, 4'b0111});
        repeat (3) @(posedge clk);
        #1;

        // 6: reset during ISSUE discards the op
        r0_a = 8'h11; r0_b = 8'h22; r0_s = 3'd1; r0_valid = 1;
        wait_ready(got, at);
        chk("t6_ready", got, 0);
        @(posedge clk); #1;
        r0_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_rvalid", {30'd0, r0_rvalid, r1_rvalid}, 32'd0);
        chk("t6_outputs", {13'd0, alu_a, alu_b, alu_s}, 32'd0);
        chk("t6_resflags", {19'd0, grant_id, r0_result, r0_flags}, 32'd0);
        @(posedge clk); #1;
        push(1'b0, 8'h7E, 4'b0010);
        push(1'b1, 8'hFF, 4'b0111);
        r0_a = 8'h7F; r0_b = 8'h01; r0_s = 3'd6; r0_valid = 1;
        r1_a = 8'hFF; r1_b = 8'h00; r1_s = 3'd3; r1_valid = 1;
        wait_ready(got, at);
        chk("t6_next_grant", got, 0);
        @(posedge clk); #1;
        r0_valid = 0;
        wait_ready(got, at);
        chk("t6_then_r1", got, 1);
        @(posedge clk); #1;
        r1_valid = 0;

        repeat (10) @(posedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
